// File: rtl/semaforo_sched.sv
// rtl/semaforo_sched.sv - two-way intersection phase scheduler with pedestrian walk and emergency preemption
module semaforo_sched #(
  parameter int T_MIN_GREEN = 8,
  parameter int T_MAX_GREEN = 20,
  parameter int T_YEL       = 4,
  parameter int T_ALLRED    = 2,
  parameter int T_WALK      = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       TA,
  input  logic       TB,
  input  logic       P,
  input  logic       R,
  output logic [1:0] LA,
  output logic [1:0] LB,
  output logic       WALK,
  output logic       on
);

  typedef enum logic [2:0] {
    A_GRN  = 3'd0,
    A_YEL  = 3'd1,
    B_GRN  = 3'd2,
    B_YEL  = 3'd3,
    ALLRED = 3'd4,
    WALK_S = 3'd5,
    EMERG  = 3'd6
  } state_t;

  localparam logic [7:0] MIN_END = 8'(T_MIN_GREEN - 1);
  localparam logic [7:0] MAX_END = 8'(T_MAX_GREEN - 1);
  localparam logic [7:0] YEL_END = 8'(T_YEL - 1);
  localparam logic [7:0] AR_END  = 8'(T_ALLRED - 1);
  localparam logic [7:0] WLK_END = 8'(T_WALK - 1);

  state_t     state;
  state_t     state_nx;
  logic [7:0] tmr;
  logic       ped_pend;
  logic       emg_pend;
  logic       nxt;
  logic       nxt_nx;
  logic       emg;
  logic       a_go;
  logic       b_go;

  assign emg = R | emg_pend;

  // A green yields only when the other side wants service and either A is idle,
  // a pedestrian is waiting, or A has had its maximum green.
  assign a_go = (tmr >= MIN_END) && (TB || ped_pend) &&
                (!TA || ped_pend || (tmr >= MAX_END));
  assign b_go = (tmr >= MIN_END) && (TA || ped_pend) &&
                (!TB || ped_pend || (tmr >= MAX_END));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= A_GRN;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    nxt_nx   = nxt;
    case (state)
      A_GRN: begin
        if (emg || a_go) begin
          state_nx = A_YEL;
          nxt_nx   = 1'b1;
        end
      end
      B_GRN: begin
        if (emg || b_go) begin
          state_nx = B_YEL;
          nxt_nx   = 1'b0;
        end
      end
      A_YEL, B_YEL: begin
        if (tmr == YEL_END) begin
          state_nx = emg ? EMERG : ALLRED;
        end
      end
      ALLRED: begin
        if (emg) begin
          state_nx = EMERG;
        end else if (tmr == AR_END) begin
          if (ped_pend) begin
            state_nx = WALK_S;
          end else begin
            state_nx = nxt ? B_GRN : A_GRN;
          end
        end
      end
      WALK_S: begin
        if (emg) begin
          state_nx = EMERG;
        end else if (tmr == WLK_END) begin
          state_nx = nxt ? B_GRN : A_GRN;
        end
      end
      EMERG: begin
        if (!R) begin
          state_nx = ALLRED;
          nxt_nx   = 1'b0;
        end
      end
      default: state_nx = A_GRN;
    endcase
  end

  // Latches clear on entry to the state that serves them; the emergency latch
  // also stays clear while EMERG holds so release does not re-trigger preemption.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr      <= 8'd0;
      ped_pend <= 1'b0;
      emg_pend <= 1'b0;
      nxt      <= 1'b1;
    end else begin
      nxt <= nxt_nx;
      if (state_nx != state) begin
        tmr <= 8'd0;
      end else if (tmr != 8'hFF) begin
        tmr <= tmr + 8'd1;
      end
      if (state_nx == WALK_S) begin
        ped_pend <= 1'b0;
      end else if (P && (state != WALK_S)) begin
        ped_pend <= 1'b1;
      end
      if (state_nx == EMERG) begin
        emg_pend <= 1'b0;
      end else if (R) begin
        emg_pend <= 1'b1;
      end
    end
  end

  always_comb begin
    LA   = 2'b10;
    LB   = 2'b10;
    WALK = 1'b0;
    on   = 1'b1;
    case (state)
      A_GRN:  LA = 2'b00;
      A_YEL:  LA = 2'b01;
      B_GRN:  LB = 2'b00;
      B_YEL:  LB = 2'b01;
      WALK_S: WALK = 1'b1;
      EMERG:  on = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_semaforo_sched.sv
// tb/tb_semaforo_sched.sv - directed table-driven bench for semaforo_sched
module tb_semaforo_sched;

  logic       clk;
  logic       rst;
  logic       TA;
  logic       TB;
  logic       P;
  logic       R;
  logic [1:0] LA;
  logic [1:0] LB;
  logic       WALK;
  logic       on;

  int nchecks;
  int nerr;

  semaforo_sched dut (
    .clk (clk),
    .rst (rst),
    .TA  (TA),
    .TB  (TB),
    .P   (P),
    .R   (R),
    .LA  (LA),
    .LB  (LB),
    .WALK(WALK),
    .on  (on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ta;
    logic       tb;
    int         lo;
    int         hi;
    logic [1:0] la;
    logic [1:0] lb;
    logic       walk;
    logic       on;
  } vec_t;

  vec_t vecs[10];

  localparam logic [5:0] A_G  = 6'b00_10_0_1;
  localparam logic [5:0] A_Y  = 6'b01_10_0_1;
  localparam logic [5:0] B_G  = 6'b10_00_0_1;
  localparam logic [5:0] B_Y  = 6'b10_01_0_1;
  localparam logic [5:0] RED  = 6'b10_10_0_1;
  localparam logic [5:0] WLK  = 6'b10_10_1_1;
  localparam logic [5:0] EMG  = 6'b10_10_0_0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    TA  = 1'b0;
    TB  = 1'b0;
    P   = 1'b0;
    R   = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic check(input string nm, input int cyc, input logic [5:0] exp);
    nchecks++;
    if ({LA, LB, WALK, on} !== exp) begin
      nerr++;
      $display("FAIL %s cycle %0d: got {LA,LB,WALK,on}=%b required %b", nm, cyc,
               {LA, LB, WALK, on}, exp);
    end
  endtask

  function automatic logic [5:0] exp_ped(input int c);
    if (c <= 7) return A_G;
    if (c <= 11) return A_Y;
    if (c <= 13) return RED;
    if (c <= 19) return WLK;
    if (c <= 27) return B_G;
    if (c <= 31) return B_Y;
    if (c <= 33) return RED;
    return A_G;
  endfunction

  function automatic logic [5:0] exp_emg(input int c);
    if (c <= 7) return A_G;
    if (c <= 11) return A_Y;
    if (c <= 13) return RED;
    if (c <= 16) return B_G;
    if (c <= 20) return B_Y;
    if (c <= 26) return EMG;
    if (c <= 28) return RED;
    return A_G;
  endfunction

  initial begin
    nchecks = 0;
    nerr    = 0;
    rst = 1'b1;
    TA  = 1'b0;
    TB  = 1'b0;
    P   = 1'b0;
    R   = 1'b0;

    vecs[0] = '{1'b0, 1'b1, 0,   7, 2'b00, 2'b10, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 8,  11, 2'b01, 2'b10, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 12, 13, 2'b10, 2'b10, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 14, 40, 2'b10, 2'b00, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 0,  19, 2'b00, 2'b10, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 20, 23, 2'b01, 2'b10, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 24, 25, 2'b10, 2'b10, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 26, 45, 2'b10, 2'b00, 1'b0, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 46, 49, 2'b10, 2'b01, 1'b0, 1'b1};
    vecs[9] = '{1'b1, 1'b0, 0, 199, 2'b00, 2'b10, 1'b0, 1'b1};

    do_reset();
    check("reset_state", 0, A_G);

    for (int v = 0; v < 10; v++) begin
      do_reset();
      TA = vecs[v].ta;
      TB = vecs[v].tb;
      for (int c = 0; c <= vecs[v].hi; c++) begin
        if (c >= vecs[v].lo) begin
          check($sformatf("vec%0d", v), c,
                {vecs[v].la, vecs[v].lb, vecs[v].walk, vecs[v].on});
        end
        tick();
      end
    end

    // pedestrian pulse at cycle 3, second pulse during walk must be ignored
    do_reset();
    TA = 1'b1;
    TB = 1'b0;
    for (int c = 0; c <= 45; c++) begin
      P = (c == 3) || (c == 16);
      check("ped_walk", c, exp_ped(c));
      tick();
    end
    P = 1'b0;

    // preemption raised two cycles into B green, held ten cycles
    do_reset();
    TA = 1'b0;
    TB = 1'b1;
    for (int c = 0; c <= 35; c++) begin
      R = (c >= 16) && (c <= 25);
      check("emerg", c, exp_emg(c));
      tick();
    end
    R = 1'b0;

    // reset in the middle of a walk phase
    do_reset();
    TA = 1'b1;
    TB = 1'b0;
    for (int c = 0; c <= 16; c++) begin
      P = (c == 3) || (c == 16);
      check("rst_walk_pre", c, exp_ped(c));
      if (c == 16) rst = 1'b1;
      tick();
    end
    rst = 1'b0;
    P   = 1'b0;
    for (int c = 0; c < 30; c++) begin
      check("rst_walk_post", c, A_G);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
